// File: rtl/ser_pkg.sv
// Shared definitions for the serializer arbiter and anything that drives or models the serializer.
package ser_pkg;

  localparam int WIDTH   = 16;
  localparam int W_INDEX = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE
  } state_t;

  // Number of serial bits the serializer emits for a length code: 0 means a full word, 1 and 2 emit nothing.
  function automatic logic [W_INDEX:0] valid_bits(input logic [W_INDEX-1:0] mod);
    if (mod == '0)
      return (W_INDEX+1)'(WIDTH);
    else if (mod == W_INDEX'(1) || mod == W_INDEX'(2))
      return '0;
    else
      return {1'b0, mod};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request strictly after the pointer, wrapping at N.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_val
);

  always_comb begin
    int k;
    // NOTE: every output gets a default before the search so no path can infer a latch.
    k         = 0;
    grant     = '0;
    grant_idx = '0;
    grant_val = 1'b0;
    for (int i = 1; i <= N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!grant_val && req[k]) begin
        grant[k]  = 1'b1;
        grant_idx = ID_W'(k);
        grant_val = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ser_arbiter.sv
// Round-robin scheduler that feeds one shared serializer, one job at a time, from N_REQ requesters.
module ser_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 16,
  parameter int W_INDEX = $clog2(WIDTH),
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [N_REQ*WIDTH-1:0]     req_data_i,
  input  logic [N_REQ*W_INDEX-1:0]   req_mod_i,
  input  logic [N_REQ-1:0]           req_val_i,
  output logic [N_REQ-1:0]           req_rdy_o,
  output logic [WIDTH-1:0]           ser_data_o,
  output logic [W_INDEX-1:0]         ser_mod_o,
  output logic                       ser_val_o,
  input  logic                       ser_busy_i,
  output logic [ID_W-1:0]            grant_id_o,
  output logic                       grant_val_o,
  output logic [N_REQ-1:0]           drop_o,
  output logic                       err_o
);

  import ser_pkg::*;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_q, grant_id_q, win_idx;
  logic [N_REQ-1:0]   win_oh, drop_q;
  logic               win_any, win_drop, take, to_expire;
  logic [WIDTH-1:0]   data_q, win_data;
  logic [W_INDEX-1:0] mod_q, win_mod;
  logic               to_cnt_q, err_q;

  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
    .req       (req_val_i),
    .ptr       (rr_q),
    .grant     (win_oh),
    .grant_idx (win_idx),
    .grant_val (win_any)
  );

  assign win_data = req_data_i[int'(win_idx)*WIDTH +: WIDTH];
  assign win_mod  = req_mod_i[int'(win_idx)*W_INDEX +: W_INDEX];
  // Codes 1 and 2 produce no serial bits, so those words are consumed here without a launch.
  assign win_drop = (win_mod == W_INDEX'(1)) || (win_mod == W_INDEX'(2));

  always_comb begin
    state_d     = state_q;
    req_rdy_o   = '0;
    ser_val_o   = 1'b0;
    grant_val_o = 1'b0;
    take        = 1'b0;
    to_expire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any && !ser_busy_i && !srst_i) begin
          req_rdy_o = win_oh;
          take      = 1'b1;
          if (!win_drop) state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        ser_val_o   = 1'b1;
        grant_val_o = 1'b1;
        state_d     = WAIT_START;
      end
      WAIT_START: begin
        grant_val_o = 1'b1;
        if (ser_busy_i) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q) begin
          to_expire = 1'b1;
          state_d   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (ser_busy_i) grant_val_o = 1'b1;
        else            state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      rr_q       <= ID_W'(N_REQ-1);
      grant_id_q <= '0;
      data_q     <= '0;
      mod_q      <= '0;
      drop_q     <= '0;
      to_cnt_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      drop_q   <= (take && win_drop) ? win_oh : '0;
      to_cnt_q <= (state_q == WAIT_START) && !ser_busy_i && !to_cnt_q;
      if (to_expire) err_q <= 1'b1;
      if (take) begin
        rr_q <= win_idx;
        if (!win_drop) begin
          data_q     <= win_data;
          mod_q      <= win_mod;
          grant_id_q <= win_idx;
        end
      end
    end
  end

  assign ser_data_o = data_q;
  assign ser_mod_o  = mod_q;
  assign grant_id_o = grant_id_q;
  assign drop_o     = drop_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_ser_arbiter.sv
// Directed bench for ser_arbiter with a behavioural serializer and a launch scoreboard.
module tb_ser_arbiter;

  import ser_pkg::*;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                     clk_i = 1'b0;
  logic                     srst_i = 1'b1;
  logic [N_REQ*WIDTH-1:0]   req_data_i;
  logic [N_REQ*W_INDEX-1:0] req_mod_i;
  logic [N_REQ-1:0]         req_val_i;
  logic [N_REQ-1:0]         req_rdy_o;
  logic [WIDTH-1:0]         ser_data_o;
  logic [W_INDEX-1:0]       ser_mod_o;
  logic                     ser_val_o;
  logic                     ser_busy_i;
  logic [ID_W-1:0]          grant_id_o;
  logic                     grant_val_o;
  logic [N_REQ-1:0]         drop_o;
  logic                     err_o;

  ser_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .W_INDEX(W_INDEX), .ID_W(ID_W)) dut (
    .clk_i       (clk_i),
    .srst_i      (srst_i),
    .req_data_i  (req_data_i),
    .req_mod_i   (req_mod_i),
    .req_val_i   (req_val_i),
    .req_rdy_o   (req_rdy_o),
    .ser_data_o  (ser_data_o),
    .ser_mod_o   (ser_mod_o),
    .ser_val_o   (ser_val_o),
    .ser_busy_i  (ser_busy_i),
    .grant_id_o  (grant_id_o),
    .grant_val_o (grant_val_o),
    .drop_o      (drop_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Serializer model: loads on ser_val_o, stays busy for valid_bits(mod) cycles, MSB first.
  logic             busy_m = 1'b0;
  logic [WIDTH-1:0] sh_m   = '0;
  logic [W_INDEX:0] cnt_m  = '0;
  logic             stuck  = 1'b0;
  assign ser_busy_i = busy_m;

  always @(posedge clk_i) begin
    if (srst_i) begin
      busy_m <= 1'b0;
      cnt_m  <= '0;
      sh_m   <= '0;
    end else if (busy_m) begin
      sh_m  <= sh_m << 1;
      cnt_m <= cnt_m - 1'b1;
      if (cnt_m == 1) busy_m <= 1'b0;
    end else if (ser_val_o && !stuck) begin
      sh_m   <= ser_data_o;
      cnt_m  <= valid_bits(ser_mod_o);
      busy_m <= (valid_bits(ser_mod_o) != 0);
    end
  end

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
    logic [W_INDEX-1:0] mod;
  } job_t;

  job_t             launch_q[$];
  int               acc_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  logic             chk_en = 1'b0;
  logic [N_REQ-1:0] exp_drop = '0;
  logic [N_REQ-1:0] hold = '0;
  int               cur_id = 0;
  logic [15:0]      bits = '0;
  int               nbits = 0;
  int               cyc = 0;
  int               launch_cyc = -1;
  int               n_drop_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, then act on the handshakes of the rising edge.
  task automatic tick();
    logic [N_REQ-1:0] rdy_s, val_s;
    job_t e;
    @(negedge clk_i);
    rdy_s = req_rdy_o;
    val_s = req_val_i;
    if (chk_en) begin
      check("rdy_onehot0", 64'($onehot0(rdy_s)), 64'd1);
      check("drop", 64'(drop_o), 64'(exp_drop));
      n_drop_seen += $countones(drop_o);
      if (ser_val_o === 1'b1) begin
        check("launch_while_busy", 64'(ser_busy_i), 64'd0);
        check("launch_expected", 64'(launch_q.size() > 0), 64'd1);
        if (launch_q.size() > 0) begin
          e = launch_q.pop_front();
          check("launch_id", 64'(grant_id_o), 64'(e.id));
          check("launch_data", 64'(ser_data_o), 64'(e.data));
          check("launch_mod", 64'(ser_mod_o), 64'(e.mod));
          cur_id     = e.id;
          launch_cyc = cyc;
        end
      end
      if (grant_val_o === 1'b1) check("grant_id_hold", 64'(grant_id_o), 64'(cur_id));
      if (ser_busy_i) begin
        bits = {bits[14:0], sh_m[WIDTH-1]};
        nbits++;
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
    exp_drop = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (val_s[k] && rdy_s[k]) begin
        acc_q.push_back(k);
        if (req_mod_i[k*W_INDEX +: W_INDEX] inside {4'd1, 4'd2}) begin
          exp_drop[k] = 1'b1;
        end else begin
          e.id   = k;
          e.data = req_data_i[k*WIDTH +: WIDTH];
          e.mod  = req_mod_i[k*W_INDEX +: W_INDEX];
          launch_q.push_back(e);
        end
        if (!hold[k]) req_val_i[k] = 1'b0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    srst_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk_en = 1'b1;
      check("reset_outputs",
            64'({ser_data_o, ser_mod_o, ser_val_o, grant_id_o, grant_val_o, drop_o, err_o, req_rdy_o}),
            64'd0);
    end
    srst_i = 1'b0;
    launch_q.delete();
    acc_q.delete();
    exp_drop = '0;
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 300 && acc_q.size() < n; i++) tick();
    check("accept_timeout", 64'(acc_q.size() >= n), 64'd1);
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 300 && quiet < 3; i++) begin
      tick();
      if (!grant_val_o && !ser_busy_i && req_val_i == '0 && launch_q.size() == 0) quiet++;
      else quiet = 0;
    end
    check("idle_timeout", 64'(quiet >= 3), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_val_i  = '0;
    req_data_i = '0;
    req_mod_i  = '0;

    // Reset with every requester valid and holding, then a full round-robin rotation.
    for (int k = 0; k < N_REQ; k++) begin
      req_data_i[k*WIDTH +: WIDTH]     = 16'h1111 * 16'(k + 1);
      req_mod_i[k*W_INDEX +: W_INDEX]  = 4'd4;
    end
    hold      = '1;
    req_val_i = '1;
    do_reset(2);
    wait_acc(5);
    req_val_i = '0;
    hold      = '0;
    if (acc_q.size() >= 5)
      for (int i = 0; i < 5; i++) check("rr_order", 64'(acc_q[i]), 64'(i % N_REQ));
    wait_idle();

    // Single full-width job from requester 2, serial stream captured from the model.
    acc_q.delete();
    bits  = '0;
    nbits = 0;
    req_data_i[2*WIDTH +: WIDTH]    = 16'hA5C3;
    req_mod_i[2*W_INDEX +: W_INDEX] = 4'd0;
    req_val_i[2] = 1'b1;
    wait_acc(1);
    if (acc_q.size() >= 1) check("single_grant", 64'(acc_q[0]), 64'd2);
    wait_idle();
    check("serial_bits", 64'(bits), 64'(16'b1010010111000011));
    check("serial_count", 64'(nbits), 64'd16);

    // Ignored length codes are dropped in arbitration order without a launch.
    do_reset(1);
    n_drop_seen = 0;
    req_mod_i[1*W_INDEX +: W_INDEX] = 4'd1;
    req_mod_i[3*W_INDEX +: W_INDEX] = 4'd2;
    req_val_i = 4'b1010;
    wait_acc(2);
    if (acc_q.size() >= 2) begin
      check("drop_order_first", 64'(acc_q[0]), 64'd1);
      check("drop_order_second", 64'(acc_q[1]), 64'd3);
    end
    wait_idle();
    check("drop_count", 64'(n_drop_seen), 64'd2);

    // A drop from requester 0 moves the pointer to 0, so requester 1 wins next.
    acc_q.delete();
    req_mod_i[0*W_INDEX +: W_INDEX] = 4'd1;
    req_val_i[0] = 1'b1;
    wait_acc(1);
    wait_idle();
    acc_q.delete();
    req_mod_i[0*W_INDEX +: W_INDEX] = 4'd4;
    req_mod_i[1*W_INDEX +: W_INDEX] = 4'd4;
    req_val_i = 4'b0011;
    wait_acc(2);
    if (acc_q.size() >= 2) begin
      check("rr_after_drop", 64'(acc_q[0]), 64'd1);
      check("rr_after_drop_next", 64'(acc_q[1]), 64'd0);
    end
    wait_idle();

    // Serializer never goes busy: error after the start window, sticky until reset.
    do_reset(1);
    stuck      = 1'b1;
    launch_cyc = -1;
    req_mod_i[0*W_INDEX +: W_INDEX] = 4'd5;
    req_val_i = 4'b0001;
    for (int i = 0; i < 20 && err_o !== 1'b1; i++) tick();
    check("err_set", 64'(err_o), 64'd1);
    check("err_latency", 64'(cyc - launch_cyc), 64'd3);
    check("err_back_idle", 64'(grant_val_o), 64'd0);
    stuck = 1'b0;
    req_mod_i[1*W_INDEX +: W_INDEX] = 4'd3;
    req_val_i = 4'b0010;
    wait_idle();
    check("err_sticky", 64'(err_o), 64'd1);
    do_reset(1);

    // Reset in the middle of a 16-bit job returns the pointer to N_REQ-1.
    req_data_i[2*WIDTH +: WIDTH]    = 16'h0FF0;
    req_mod_i[2*W_INDEX +: W_INDEX] = 4'd0;
    req_val_i = 4'b0100;
    wait_acc(1);
    repeat (6) tick();
    check("mid_job_busy", 64'(ser_busy_i), 64'd1);
    do_reset(1);
    check("mid_reset_serializer_idle", 64'(ser_busy_i), 64'd0);
    req_mod_i[2*W_INDEX +: W_INDEX] = 4'd4;
    req_mod_i[3*W_INDEX +: W_INDEX] = 4'd4;
    req_val_i = 4'b1100;
    wait_acc(2);
    if (acc_q.size() >= 2) begin
      check("rr_after_reset", 64'(acc_q[0]), 64'd2);
      check("rr_after_reset_next", 64'(acc_q[1]), 64'd3);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
